// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - microcode fetch/sequencing controller for the ROM-driven datapath
module fetch_sequencer #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3,
  parameter int W               = 4 + 2 * RF_addressBits
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ROM_readEnable,
  output logic [ROM_addressBits-1:0] ROM_address,
  input  logic [W-1:0]               ROM_data,
  output logic [W-1:0]               instruction,
  output logic                       instr_valid,
  input  logic                       exec_done,
  input  logic                       zero_flag,
  input  logic                       neg_flag,
  output logic                       halted
);

  localparam int AW = ROM_addressBits;
  localparam int IW = 2 * RF_addressBits;

  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_BRZ  = 4'b1100;
  localparam logic [3:0] OP_BRN  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;

  // Immediate field widened or narrowed to the PC width; widths may differ
  // between parameterisations so go through a buffer wide enough for both.
  function automatic logic [AW-1:0] to_target(input logic [IW-1:0] imm);
    logic [AW+IW-1:0] ext;
    ext = {{AW{1'b0}}, imm};
    return ext[AW-1:0];
  endfunction

  logic [3:0]    opcode;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_next_seq;

  // Decode of the captured instruction; only consulted in EXEC
  always_comb begin
    opcode      = instruction[W-1:W-4];
    target      = to_target(instruction[IW-1:0]);
    pc_next_seq = pc + 1'b1;
  end

  // The ROM address is the PC register itself, so it is registered by construction
  assign ROM_address = pc;

  // Sequencer FSM with registered strobes; outputs are set on the edge entering each state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= '0;
      instruction    <= '0;
      ROM_readEnable <= 1'b0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_FETCH;
            ROM_readEnable <= 1'b1;
          end
        end

        S_FETCH: begin
          state          <= S_LOAD;
          ROM_readEnable <= 1'b0;
        end

        S_LOAD: begin
          instruction <= ROM_data;
          instr_valid <= 1'b1;
          state       <= S_EXEC;
        end

        S_EXEC: begin
          case (opcode)
            OP_JMP: begin
              pc             <= target;
              state          <= S_FETCH;
              instr_valid    <= 1'b0;
              ROM_readEnable <= 1'b1;
            end
            OP_BRZ: begin
              pc             <= zero_flag ? target : pc_next_seq;
              state          <= S_FETCH;
              instr_valid    <= 1'b0;
              ROM_readEnable <= 1'b1;
            end
            OP_BRN: begin
              pc             <= neg_flag ? target : pc_next_seq;
              state          <= S_FETCH;
              instr_valid    <= 1'b0;
              ROM_readEnable <= 1'b1;
            end
            OP_HALT: begin
              state       <= S_HALTED;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end
            default: begin
              // Datapath op: wait for the datapath to retire it
              if (exec_done) begin
                pc             <= pc_next_seq;
                state          <= S_FETCH;
                instr_valid    <= 1'b0;
                ROM_readEnable <= 1'b1;
              end
            end
          endcase
        end

        S_HALTED: begin
          halted         <= 1'b1;
          instr_valid    <= 1'b0;
          ROM_readEnable <= 1'b0;
        end

        default: begin
          state          <= S_IDLE;
          ROM_readEnable <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int AW = 6;
  localparam int W  = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ROM_readEnable;
  logic [AW-1:0] ROM_address;
  logic [W-1:0]  ROM_data;
  logic [W-1:0]  instruction;
  logic          instr_valid;
  logic          exec_done;
  logic          zero_flag;
  logic          neg_flag;
  logic          halted;

  int n_checks;
  int n_fail;

  logic [W-1:0] rom [0:(1<<AW)-1];
  logic [W-1:0] rom_q;

  fetch_sequencer #(.ROM_addressBits(6), .RF_addressBits(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ROM_readEnable (ROM_readEnable),
    .ROM_address    (ROM_address),
    .ROM_data       (ROM_data),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .exec_done      (exec_done),
    .zero_flag      (zero_flag),
    .neg_flag       (neg_flag),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered ROM
  initial rom_q = '0;
  always @(posedge clk) if (ROM_readEnable) rom_q <= rom[ROM_address];
  assign ROM_data = rom_q;

  function automatic logic [W-1:0] ins(input logic [3:0] op, input logic [5:0] imm);
    return {op, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [AW-1:0] addr);
    chk({tag, "_rd"}, 32'(ROM_readEnable), 32'd1);
    chk({tag, "_addr"}, 32'(ROM_address), 32'(addr));
    chk({tag, "_iv"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    exec_done = 1'b0;
    zero_flag = 1'b0;
    neg_flag  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = ins(4'b0010, 6'(i));
    rom[0]  = ins(4'b0001, 6'd5);
    rom[1]  = ins(4'b1011, 6'd20);
    rom[20] = ins(4'b1100, 6'd9);
    rom[9]  = ins(4'b1100, 6'd30);
    rom[10] = ins(4'b1101, 6'd40);
    rom[40] = ins(4'b1101, 6'd50);
    rom[41] = ins(4'b1011, 6'd63);
    rom[63] = ins(4'b0011, 6'd7);
    rom[4]  = ins(4'b1111, 6'd0);

    // Reset state
    step(); step();
    chk("rst_rd", 32'(ROM_readEnable), 32'd0);
    chk("rst_addr", 32'(ROM_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_rd", 32'(ROM_readEnable), 32'd0);

    // 1: datapath op at 0, exec_done already high
    start = 1'b1; exec_done = 1'b1;
    step();
    chk_fetch("t1_fetch0", 6'd0);
    start = 1'b0;
    step();
    chk("t1_load_rd", 32'(ROM_readEnable), 32'd0);
    chk("t1_load_iv", 32'(instr_valid), 32'd0);
    step();
    chk("t1_exec_iv", 32'(instr_valid), 32'd1);
    chk("t1_exec_instr", 32'(instruction), 32'(rom[0]));
    step();
    chk_fetch("t1_fetch1", 6'd1);

    // 2: JMP 20, exec_done pulses ignored
    exec_done = 1'b0;
    step();
    exec_done = 1'b1;
    step();
    chk("t2_exec_instr", 32'(instruction), 32'(ins(4'b1011, 6'd20)));
    chk("t2_exec_iv", 32'(instr_valid), 32'd1);
    exec_done = 1'b0;
    step();
    chk_fetch("t2_jmp", 6'd20);

    // 3: branches taken / not taken
    zero_flag = 1'b1;
    step(); step(); step();
    chk_fetch("t3_brz_taken", 6'd9);
    zero_flag = 1'b0;
    step(); step(); step();
    chk_fetch("t3_brz_not", 6'd10);
    neg_flag = 1'b1;
    step(); step(); step();
    chk_fetch("t3_brn_taken", 6'd40);
    neg_flag = 1'b0;
    step(); step(); step();
    chk_fetch("t3_brn_not", 6'd41);
    step(); step(); step();
    chk_fetch("t3_jmp63", 6'd63);

    // 4: PC wraps 63 -> 0
    exec_done = 1'b1;
    step(); step(); step();
    chk_fetch("t4_wrap", 6'd0);

    // 5: exec_done held low keeps EXEC
    rom[1] = ins(4'b1011, 6'd4);
    exec_done = 1'b0;
    zero_flag = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_iv", 32'(instr_valid), 32'd1);
      chk("t5_rd", 32'(ROM_readEnable), 32'd0);
      chk("t5_instr", 32'(instruction), 32'(rom[0]));
      step();
    end
    zero_flag = 1'b0;
    exec_done = 1'b1;
    chk("t5_still_exec", 32'(instr_valid), 32'd1);
    step();
    chk_fetch("t5_release", 6'd1);

    // 6: HALT at 4
    step(); step(); step();
    chk_fetch("t6_fetch4", 6'd4);
    step(); step();
    chk("t6_exec_instr", 32'(instruction), 32'(ins(4'b1111, 6'd0)));
    step();
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_halt_iv", 32'(instr_valid), 32'd0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_halt_sticky", 32'(halted), 32'd1);
      chk("t6_halt_rd", 32'(ROM_readEnable), 32'd0);
      chk("t6_halt_addr", 32'(ROM_address), 32'd4);
    end
    start = 1'b0;

    // Reset from HALTED, then reset mid-LOAD at PC=1
    rst_n = 1'b0;
    #1;
    chk("t6_rst_halt", 32'(halted), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; exec_done = 1'b1;
    step();
    chk_fetch("t6_refetch0", 6'd0);
    start = 1'b0;
    step(); step(); step();
    chk_fetch("t6_refetch1", 6'd1);
    step();
    chk("t6_load_instr", 32'(instruction), 32'(rom[0]));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_abort_addr", 32'(ROM_address), 32'd0);
    chk("t6_abort_instr", 32'(instruction), 32'd0);
    chk("t6_abort_rd", 32'(ROM_readEnable), 32'd0);
    chk("t6_abort_iv", 32'(instr_valid), 32'd0);
    chk("t6_abort_halt", 32'(halted), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_idle", 32'(ROM_readEnable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
